ddr_rx_fifo: RTL and testbench
==============================

DDR_RX_FIFO -- requirements
Module: ddr_rx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entries (power of two, 4..64).
REQ-002 SHALL have parameter AFULL_THRESH, default 12, occupancy at which o_almost_full asserts.
REQ-003 SHALL have port i_sys_clk  input  1  system clock; all logic rising-edge.
REQ-004 SHALL have port i_sys_rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port i_rx_byte_valid  input  1  one-cycle strobe: received DDR data byte present.
REQ-006 SHALL have port i_rx_byte  input  8  received byte, qualified by i_rx_byte_valid.
REQ-007 SHALL have port i_rx_last  input  1  marks the strobed byte as the final byte of the transfer.
REQ-008 SHALL have port i_flush  input  1  synchronous clear on abort or error.
REQ-009 SHALL have port i_regf_rd_req  input  1  register-file pop request.
REQ-010 SHALL have port o_regf_rd_data  output  8  popped byte, registered.
REQ-011 SHALL have port o_regf_rd_valid  output  1  o_regf_rd_data valid, single-cycle pulse.
REQ-012 SHALL have port o_fifo_empty  output  1  occupancy == 0.
REQ-013 SHALL have port o_almost_full  output  1  occupancy >= AFULL_THRESH.
REQ-014 SHALL have port o_fifo_count  output  log2(DEPTH)+1  current occupancy.
REQ-015 SHALL have port o_overflow  output  1  sticky: write dropped because FIFO was full.
REQ-016 SHALL have port o_xfer_done  output  1  one-cycle pulse when the last-marked byte is popped.

Function
REQ-017 SHALL store DEPTH entries of 9 bits each ({last, byte}), with write pointer, read pointer and occupancy counter.
REQ-018 SHALL write on i_rx_byte_valid when not full: entry at wr_ptr, wr_ptr+1 modulo DEPTH, count+1.
REQ-019 SHALL drop a write attempted while full, leave pointers and count unchanged, and set o_overflow until flush or reset.
REQ-020 SHALL pop on i_regf_rd_req when not empty; o_regf_rd_data and o_regf_rd_valid update on the next clock edge (latency 1), and rd_ptr+1 modulo DEPTH, count-1.
REQ-021 SHALL ignore i_regf_rd_req when empty: o_regf_rd_valid stays 0, no underflow side effect, and o_regf_rd_data holds its previous value.
REQ-022 SHALL perform a simultaneous write and pop when neither is blocked, leaving count unchanged; when empty, the write occurs and the pop is ignored; when full, the pop frees an entry in the same cycle, so the write is accepted.
REQ-023 SHALL wrap both pointers from DEPTH-1 to 0 without gaps.
REQ-024 SHALL implement a state machine IDLE, ACTIVE, DRAIN with these transitions:
- IDLE->ACTIVE on the first accepted write.
- ACTIVE->DRAIN on an accepted write with i_rx_last=1.
- DRAIN->IDLE on the cycle the last-marked entry is popped; o_xfer_done pulses 1 cycle later, aligned with o_regf_rd_valid.
REQ-025 SHALL ignore i_rx_byte_valid while in DRAIN; the byte is not stored and o_overflow is not set.
REQ-026 SHALL accept a last-marked write from IDLE as a single-byte transfer, going directly to DRAIN.
REQ-027 SHALL, on i_flush, reset pointers, count, o_overflow and state to IDLE on the next edge; flush overrides any same-cycle write or pop, o_regf_rd_valid and o_xfer_done are 0 in the following cycle, and o_regf_rd_data keeps its value.
REQ-028 SHALL derive o_fifo_empty, o_almost_full and o_fifo_count combinationally from the registered count.

Reset
REQ-029 SHALL, on i_sys_rst=1 and regardless of clock, drive pointers=0, count=0, state=IDLE, o_regf_rd_data=8'h00, o_regf_rd_valid=0, o_overflow=0, o_xfer_done=0, o_fifo_empty=1, o_almost_full=0, o_fifo_count=0.
REQ-030 SHALL discard all stored data when reset asserts mid-transfer; storage contents need not be cleared, but no entry is readable after reset.

Verification
REQ-031 Bench SHALL cover basic order: write 8'hA1, 8'hB2, 8'hC3 (last on C3), then pop 3 times -> data A1, B2, C3 each 1 cycle after its request, o_xfer_done with C3, state IDLE, o_fifo_empty=1.
REQ-032 Bench SHALL cover full: write 17 bytes into DEPTH=16 -> count=16, o_almost_full=1 from the 12th write, 17th dropped, o_overflow=1 and sticky.
REQ-033 Bench SHALL cover simultaneous: count=16, write+pop same cycle -> write accepted, count stays 16, o_overflow stays 0; count=0, write+pop -> count=1, no rd_valid.
REQ-034 Bench SHALL cover wrap: 40 write/pop pairs of an incrementing pattern -> all bytes read in order, pointers wrap at 15->0.
REQ-035 Bench SHALL cover flush/reset: i_flush with count=5 and o_overflow=1 -> count=0, o_overflow=0, IDLE next cycle; i_sys_rst asserted mid-cycle -> outputs at reset values immediately.
REQ-036 Bench SHALL cover DRAIN lockout: last byte written, then 2 extra strobes -> not stored, count unchanged, o_overflow=0.

Source files
------------

// File: rtl/ddr_rx_fifo.sv
// Receive-byte FIFO between a DDR capture path and a register-file reader, tracking one transfer at a time.
// Latency: a pop request returns its byte one clock later; occupancy flags follow the registered count.
// Backpressure: none upstream; writes while full are dropped (sticky overflow), strobes during DRAIN are ignored.
module ddr_rx_fifo #(
    parameter int DEPTH        = 16,
    parameter int AFULL_THRESH = 12
) (
    input  logic                     i_sys_clk,
    input  logic                     i_sys_rst,
    input  logic                     i_rx_byte_valid,
    input  logic [7:0]               i_rx_byte,
    input  logic                     i_rx_last,
    input  logic                     i_flush,
    input  logic                     i_regf_rd_req,
    output logic [7:0]               o_regf_rd_data,
    output logic                     o_regf_rd_valid,
    output logic                     o_fifo_empty,
    output logic                     o_almost_full,
    output logic [$clog2(DEPTH):0]   o_fifo_count,
    output logic                     o_overflow,
    output logic                     o_xfer_done
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT  = DEPTH[AW:0];
    localparam logic [AW:0] AFULL_CNT = AFULL_THRESH[AW:0];

    typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

    state_t        state, state_nxt;
    logic [8:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          full, empty, pop_ok, wr_ok, wr_drop, head_last;

    assign empty     = (count == '0);
    assign full      = (count == FULL_CNT);
    assign head_last = mem[rd_ptr][8];
    assign pop_ok    = i_regf_rd_req && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the write.
    assign wr_ok     = i_rx_byte_valid && (state != DRAIN) && (!full || pop_ok);
    assign wr_drop   = i_rx_byte_valid && (state != DRAIN) && full && !pop_ok;

    assign o_fifo_empty  = empty;
    assign o_almost_full = (count >= AFULL_CNT);
    assign o_fifo_count  = count;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (wr_ok) state_nxt = i_rx_last ? DRAIN : ACTIVE;
            ACTIVE:  if (wr_ok && i_rx_last) state_nxt = DRAIN;
            DRAIN:   if (pop_ok && head_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_sys_clk) begin
        if (wr_ok && !i_flush) begin
            mem[wr_ptr] <= {i_rx_last, i_rx_byte};
        end
    end

    always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
        if (i_sys_rst) begin
            state           <= IDLE;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= '0;
            o_regf_rd_data  <= 8'h00;
            o_regf_rd_valid <= 1'b0;
            o_overflow      <= 1'b0;
            o_xfer_done     <= 1'b0;
        end else if (i_flush) begin
            state           <= IDLE;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= '0;
            o_regf_rd_valid <= 1'b0;
            o_overflow      <= 1'b0;
            o_xfer_done     <= 1'b0;
        end else begin
            state           <= state_nxt;
            o_regf_rd_valid <= pop_ok;
            o_xfer_done     <= pop_ok && head_last;
            if (pop_ok) begin
                o_regf_rd_data <= mem[rd_ptr][7:0];
                rd_ptr         <= rd_ptr + 1'b1;
            end
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (wr_drop) begin
                o_overflow <= 1'b1;
            end
            case ({wr_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_ddr_rx_fifo.sv
// Randomised and directed bench for ddr_rx_fifo: a queue-based reference model predicts each pop,
// and a negedge monitor checks returned bytes, their timing and the occupancy flags.
module tb_ddr_rx_fifo;

    localparam int DEPTH = 16;
    localparam int AFULL = 12;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_vld = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic       rx_last = 1'b0;
    logic       flush = 1'b0;
    logic       rd_req = 1'b0;
    logic [7:0] rd_data;
    logic       rd_valid, fifo_empty, almost_full, overflow, xfer_done;
    logic [4:0] fifo_count;

    ddr_rx_fifo #(.DEPTH(DEPTH), .AFULL_THRESH(AFULL)) dut (
        .i_sys_clk      (clk),
        .i_sys_rst      (rst),
        .i_rx_byte_valid(rx_vld),
        .i_rx_byte      (rx_byte),
        .i_rx_last      (rx_last),
        .i_flush        (flush),
        .i_regf_rd_req  (rd_req),
        .o_regf_rd_data (rd_data),
        .o_regf_rd_valid(rd_valid),
        .o_fifo_empty   (fifo_empty),
        .o_almost_full  (almost_full),
        .o_fifo_count   (fifo_count),
        .o_overflow     (overflow),
        .o_xfer_done    (xfer_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] d;
        logic       last;
        int         cyc;
    } exp_t;

    exp_t       exp_q[$];
    logic [8:0] mdl_q[$];
    bit         mdl_ovf = 1'b0;
    logic [7:0] mdl_data = 8'h00;
    int         n_cmp = 0;
    int         n_fail = 0;

    function automatic void chk(string nm, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d", nm, act, act, exp, exp, cyc);
        end
    endfunction

    // One clock of stimulus; the model predicts from plain FIFO rules and commits after the edge.
    task automatic step(input logic v, input logic [7:0] b, input logic l, input logic rd, input logic fl);
        int         sz;
        bit         lock, pop, wr, nov;
        logic [8:0] hd;
        exp_t       e;
        rx_vld  = v;
        rx_byte = b;
        rx_last = l;
        rd_req  = rd;
        flush   = fl;
        sz   = mdl_q.size();
        lock = 1'b0;
        foreach (mdl_q[i]) if (mdl_q[i][8]) lock = 1'b1;
        pop = 1'b0;
        wr  = 1'b0;
        nov = mdl_ovf;
        hd  = 9'h000;
        if (!fl) begin
            pop = rd && (sz > 0);
            wr  = v && !lock && ((sz < DEPTH) || pop);
            if (v && !lock && (sz == DEPTH) && !pop) nov = 1'b1;
            if (pop) begin
                hd    = mdl_q[0];
                e.d    = hd[7:0];
                e.last = hd[8];
                e.cyc  = cyc + 1;
                exp_q.push_back(e);
            end
        end
        @(posedge clk);
        if (fl) begin
            mdl_q.delete();
            mdl_ovf = 1'b0;
        end else begin
            if (pop) begin
                void'(mdl_q.pop_front());
                mdl_data = hd[7:0];
            end
            if (wr) mdl_q.push_back({l, b});
            mdl_ovf = nov;
        end
        #1;
    endtask

    task automatic wr_b(input logic [7:0] b, input logic l); step(1'b1, b, l, 1'b0, 1'b0); endtask
    task automatic pop1();  step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0); endtask
    task automatic idle();  step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0); endtask

    task automatic chk_reset_vals(string tag);
        chk({tag, "_count"}, int'(fifo_count), 0);
        chk({tag, "_empty"}, int'(fifo_empty), 1);
        chk({tag, "_afull"}, int'(almost_full), 0);
        chk({tag, "_ovf"},   int'(overflow), 0);
        chk({tag, "_rdvld"}, int'(rd_valid), 0);
        chk({tag, "_xdone"}, int'(xfer_done), 0);
        chk({tag, "_rdata"}, int'(rd_data), 0);
    endtask

    exp_t m_e;
    always @(negedge clk) begin
        if (!rst) begin
            chk("count", int'(fifo_count), mdl_q.size());
            chk("empty", int'(fifo_empty), int'(mdl_q.size() == 0));
            chk("almost_full", int'(almost_full), int'(mdl_q.size() >= AFULL));
            chk("overflow", int'(overflow), int'(mdl_ovf));
            chk("rd_data_hold", int'(rd_data), int'(mdl_data));
            if (rd_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_rd_valid", 1, 0);
                end else begin
                    m_e = exp_q.pop_front();
                    chk("pop_data", int'(rd_data), int'(m_e.d));
                    chk("pop_cycle", cyc, m_e.cyc);
                    chk("xfer_done", int'(xfer_done), int'(m_e.last));
                end
            end else begin
                chk("xfer_done_idle", int'(xfer_done), 0);
                if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                    chk("missing_rd_valid_at", cyc, exp_q[0].cyc - 1);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #12;
        chk_reset_vals("por");
        @(posedge clk);
        #1 rst = 1'b0;

        // Basic order with last on the third byte
        wr_b(8'hA1, 1'b0);
        wr_b(8'hB2, 1'b0);
        wr_b(8'hC3, 1'b1);
        repeat (3) pop1();
        idle();
        idle();

        // Fill past DEPTH: 17th write is dropped and overflow sticks
        for (int k = 0; k < DEPTH + 1; k++) wr_b(8'(8'h40 + k), 1'b0);
        repeat (3) idle();

        // Flush at count 5 with overflow set
        repeat (DEPTH - 5) pop1();
        step(1'b1, 8'h99, 1'b0, 1'b1, 1'b1);
        idle();

        // Simultaneous write and pop when full, then when empty
        for (int k = 0; k < DEPTH; k++) wr_b(8'(8'h60 + k), 1'b0);
        step(1'b1, 8'h7F, 1'b0, 1'b1, 1'b0);
        repeat (DEPTH) pop1();
        idle();
        step(1'b1, 8'h88, 1'b0, 1'b1, 1'b0);
        idle();
        pop1();
        pop1();
        idle();

        // Pointer wrap with an incrementing pattern
        for (int k = 0; k < 40; k++) step(1'b1, 8'(k), 1'b0, 1'b1, 1'b0);
        pop1();
        idle();

        // DRAIN lockout: strobes after the last byte are ignored
        wr_b(8'h11, 1'b0);
        wr_b(8'h22, 1'b1);
        wr_b(8'h33, 1'b0);
        wr_b(8'h44, 1'b0);
        pop1();
        pop1();
        idle();

        // Asynchronous reset in the middle of a transfer
        wr_b(8'h55, 1'b0);
        wr_b(8'h66, 1'b0);
        wr_b(8'h77, 1'b0);
        idle();
        #2 rst = 1'b1;
        #1 chk_reset_vals("async_rst");
        mdl_q.delete();
        exp_q.delete();
        mdl_ovf  = 1'b0;
        mdl_data = 8'h00;
        @(posedge clk);
        #1 rst = 1'b0;
        pop1();
        idle();

        // Random traffic
        for (int n = 0; n < 2000; n++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom),
                 1'($urandom_range(0, 15) == 0),
                 1'($urandom_range(0, 99) < 45),
                 1'($urandom_range(0, 199) == 0));
        end
        repeat (DEPTH + 2) pop1();
        repeat (3) idle();
        chk("pending_pops", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
